// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, DIFF = A - B - Bin
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             OVF
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;

    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] diff_next;
    logic             last;

    always_comb begin
        a0        = a_sr[0];
        b0        = b_sr[0];
        d         = a0 ^ b0 ^ br;
        br_next   = (~a0 & b0) | (~a0 & br) | (b0 & br);
        diff_next = {d, diff_sr[WIDTH-1:1]};
        last      = (cnt == CW'(WIDTH - 1));
    end

    // Operand MSBs are kept aside because the shift registers are consumed by the time OVF is formed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            DIFF    <= '0;
            Bout    <= 1'b0;
            OVF     <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            br      <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= A;
                        b_sr    <= B;
                        br      <= Bin;
                        a_msb   <= A[WIDTH-1];
                        b_msb   <= B[WIDTH-1];
                        cnt     <= '0;
                        diff_sr <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    br      <= br_next;
                    diff_sr <= diff_next;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        DIFF  <= diff_next;
                        Bout  <= br_next;
                        OVF   <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
